wdm_router: RTL and testbench
=============================

WDM_ROUTER -- requirements
Module: wdm_router

Interface
REQ-001 Parameter WIDTH, default 32: system word width; router_id is WIDTH/2 bits.
REQ-002 Parameter NUM_ROUTERS, default 4: routers on the waveguide; dst values >= NUM_ROUTERS are illegal.
REQ-003 Parameter NUM_CH, default 2: wavelength channels, range 1..8.
REQ-004 Parameter TX_DEPTH, default 4: TX FIFO entries, power of 2, >= 2.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ip_data_in  in  packet_t  packet from IP.
REQ-008 ip_valid_in  in  1  ip_data_in valid.
REQ-009 ip_ready_out  out  1  router can accept from IP.
REQ-010 ip_data_out  out  packet_t  received packet to IP.
REQ-011 ip_valid_out  out  1  ip_data_out valid.
REQ-012 ip_ready_in  in  1  IP can accept received packet.
REQ-013 mod_data_out  out  NUM_CH x packet_t  per-channel modulator data.
REQ-014 mod_valid_out  out  NUM_CH  per-channel modulator strobe.
REQ-015 pd_data_in  in  NUM_CH x packet_t  per-channel photodetector data.
REQ-016 pd_valid_in  in  NUM_CH  per-channel photodetector strobe.
REQ-017 request_to_send  out  1  TX FIFO non-empty.
REQ-018 permission_granted_send  in  NUM_CH  per-channel grant from arbiter.
REQ-019 router_id  in  WIDTH/2  this router's address, static after reset.
REQ-020 tx_sent_count  out  32  packets sent, wraps.
REQ-021 rx_drop_count  out  16  packets dropped on receive, saturates at 16'hFFFF.

Function
REQ-022 32-bit cycle counter increments every non-reset cycle, wraps 2^32-1 -> 0.
REQ-023 TX push when ip_valid_in && ip_ready_out; ip_ready_out = !tx_full, independent of same-cycle pop.
REQ-024 On push, stored packet = ip_data_in with src <- router_id[8:0], timestamp <- cycle counter value at push edge, valid <- 1; all other fields unchanged.
REQ-025 request_to_send = !tx_empty, combinational from FIFO count.
REQ-026 Pop when !tx_empty && |permission_granted_send; channel = lowest-index set grant bit; other grant bits ignored.
REQ-027 Pop latency 1: cycle after pop, mod_data_out[c] = popped head, mod_valid_out = one-hot bit c, high exactly one cycle.
REQ-028 Grant with tx_empty: no pop, mod_valid_out all 0, tx_sent_count unchanged.
REQ-029 mod_data_out[c] holds last sent value when not strobed.
REQ-030 tx_sent_count increments by 1 per pop.
REQ-031 Simultaneous push and pop when not full and not empty: both occur, count unchanged, FIFO order preserved.
REQ-032 Each channel c has a one-entry RX holding register (hold_valid[c], hold_data[c]).
REQ-033 Arrival on c (pd_valid_in[c]) accepted when pd_data_in[c].dst == router_id[8:0] and (hold_valid[c]==0 or hold c drained same cycle).
REQ-034 Arrival with dst != router_id: discarded, rx_drop_count +1.
REQ-035 Arrival with matching dst while hold c full and not draining: discarded, rx_drop_count +1, hold contents unchanged.
REQ-036 Several drops in one cycle: rx_drop_count adds the number of drops, saturating at 16'hFFFF.
REQ-037 RX output: round-robin pointer rr (log2 NUM_CH bits); selected channel = first c with hold_valid[c], searching from rr upward with wrap.
REQ-038 ip_valid_out = any hold_valid; ip_data_out = hold_data[selected], both combinational from registers.
REQ-039 Drain when ip_valid_out && ip_ready_in: hold_valid[selected] cleared, rr <- selected+1 mod NUM_CH; otherwise rr unchanged.
REQ-040 ip_valid_out stays high and ip_data_out stable until drained; a packet is never withdrawn.

Reset
REQ-041 While rst high at a clock edge: TX FIFO empty, all hold_valid 0, rr 0, cycle counter 0, tx_sent_count 0, rx_drop_count 0, mod_valid_out 0, mod_data_out 0.
REQ-042 Therefore ip_ready_out 1, request_to_send 0, ip_valid_out 0 one cycle after rst; reset mid-transfer discards all buffered packets silently without counting drops.

Verification
REQ-043 Push 4 packets (TX_DEPTH=4) with no grant -> ip_ready_out 0 after 4th, 5th held off; grant bit0 once -> mod_valid_out=01 next cycle with 1st packet, ip_ready_out 1.
REQ-044 Push at cycle counter 100 with router_id 3 -> sent packet timestamp 100, src 3; grant 2'b11 -> only mod_valid_out[0] strobes.
REQ-045 pd_valid_in=11, both dst=router_id, ip_ready_in=1 -> ch0 delivered, then ch1, rr ends at 0; rx_drop_count 0.
REQ-046 ip_ready_in=0, two matching arrivals on ch1 -> first held, second dropped, rx_drop_count 1; one wrong-dst arrival -> rx_drop_count 2.
REQ-047 Force rx_drop_count to 16'hFFFF via drops -> further drops keep 16'hFFFF.
REQ-048 Assert rst with 3 TX entries and 2 hold entries -> next cycle request_to_send 0, ip_valid_out 0, all counters 0.

Source files
------------

// File: rtl/wdm_router_if.sv
// Shared packet format and the bundled IP / optical-side signals of wdm_router.
// The package lives here so the interface and the router share one definition.

package wdm_router_pkg;

   // Payload is fixed at the default 32-bit system word.
   typedef struct packed {
      logic        valid;
      logic [8:0]  src;
      logic [8:0]  dst;
      logic [31:0] timestamp;
      logic [31:0] payload;
   } packet_t;

endpackage

interface wdm_router_if #(
   parameter int NUM_CH = 2
);
   import wdm_router_pkg::*;

   // IP transmit side
   packet_t           ip_data_in;
   logic              ip_valid_in;
   logic              ip_ready_out;
   // IP receive side
   packet_t           ip_data_out;
   logic              ip_valid_out;
   logic              ip_ready_in;
   // Optical side
   packet_t           mod_data_out [NUM_CH];
   logic [NUM_CH-1:0] mod_valid_out;
   packet_t           pd_data_in [NUM_CH];
   logic [NUM_CH-1:0] pd_valid_in;
   // Arbitration
   logic              request_to_send;
   logic [NUM_CH-1:0] permission_granted_send;

   // Router view
   modport master (
      input  ip_data_in, ip_valid_in, ip_ready_in,
             pd_data_in, pd_valid_in, permission_granted_send,
      output ip_ready_out, ip_data_out, ip_valid_out,
             mod_data_out, mod_valid_out, request_to_send
   );

   // Environment view
   modport slave (
      output ip_data_in, ip_valid_in, ip_ready_in,
             pd_data_in, pd_valid_in, permission_granted_send,
      input  ip_ready_out, ip_data_out, ip_valid_out,
             mod_data_out, mod_valid_out, request_to_send
   );

endinterface

// File: rtl/wdm_router.sv
// WDM optical router node: a TX FIFO feeding per-channel modulators on grant,
// and per-channel one-entry RX holds drained round-robin towards the IP.

module wdm_router
   import wdm_router_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int NUM_ROUTERS = 4,
   parameter int NUM_CH      = 2,
   parameter int TX_DEPTH    = 4
) (
   input  logic               clk,
   input  logic               rst,
   wdm_router_if.master       bus,
   input  logic [WIDTH/2-1:0] router_id,
   output logic [31:0]        tx_sent_count,
   output logic [15:0]        rx_drop_count
);

   localparam int PTR_W = $clog2(TX_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [8:0] my_id;
   assign my_id = router_id[8:0];

   // Upper address bits and the overwritten input fields are don't-cares.
   logic unused_bits;
   assign unused_bits = ^{router_id[WIDTH/2-1:9], bus.ip_data_in.valid,
                          bus.ip_data_in.src, bus.ip_data_in.timestamp};

   // ---------------- state ----------------
   logic [31:0]       cycle_q, cycle_d;
   packet_t           tx_mem_q [TX_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  tx_count_q, tx_count_d;
   logic [NUM_CH-1:0] mod_valid_q, mod_valid_d;
   packet_t           mod_data_q [NUM_CH];
   packet_t           mod_data_d [NUM_CH];
   logic [31:0]       tx_sent_q, tx_sent_d;
   logic [NUM_CH-1:0] hold_valid_q, hold_valid_d;
   packet_t           hold_data_q [NUM_CH];
   packet_t           hold_data_d [NUM_CH];
   logic [CH_W-1:0]   rr_q, rr_d;
   logic [15:0]       rx_drop_q, rx_drop_d;

   // ---------------- TX side ----------------
   logic            tx_empty, tx_full, push, pop;
   logic [CH_W-1:0] grant_ch;
   packet_t         push_pkt;

   assign tx_empty = (tx_count_q == '0);
   assign tx_full  = (tx_count_q == CNT_W'(TX_DEPTH));
   assign push     = bus.ip_valid_in && !tx_full;
   assign pop      = !tx_empty && (|bus.permission_granted_send);

   // Lowest-index grant wins: scanning downward leaves the lowest set bit last.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      grant_ch = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (bus.permission_granted_send[c]) grant_ch = CH_W'(c);
      end
   end

   // Stamp the incoming packet with our address and the current cycle count.
   always_comb begin
      push_pkt           = bus.ip_data_in;
      push_pkt.src       = my_id;
      push_pkt.timestamp = cycle_q;
      push_pkt.valid     = 1'b1;
   end

   // FIFO pointers, occupancy, cycle and sent counters.
   always_comb begin
      cycle_d    = cycle_q + 32'd1;
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      tx_count_d = tx_count_q;
      case ({push, pop})
         2'b10:   tx_count_d = tx_count_q + CNT_W'(1);
         2'b01:   tx_count_d = tx_count_q - CNT_W'(1);
         default: tx_count_d = tx_count_q;
      endcase
      tx_sent_d  = pop ? tx_sent_q + 32'd1 : tx_sent_q;
   end

   // Popped head goes to the granted channel's modulator for one strobe cycle.
   always_comb begin
      mod_valid_d = '0;
      mod_data_d  = mod_data_q;
      if (pop) begin
         mod_valid_d[grant_ch] = 1'b1;
         mod_data_d[grant_ch]  = tx_mem_q[rd_ptr_q];
      end
   end

   // FIFO storage write.
   always_ff @(posedge clk) begin
      // NOTE: payload storage is left unreset; occupancy alone says what is valid.
      if (push) tx_mem_q[wr_ptr_q] <= push_pkt;
   end

   // ---------------- RX side ----------------
   logic [CH_W-1:0] sel;
   logic            drain;
   logic [3:0]      drop_n;
   logic [16:0]     drop_sum;

   // First occupied hold searching upward from rr with wrap.
   always_comb begin
      sel = rr_q;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (hold_valid_q[(int'(rr_q) + i) % NUM_CH]) sel = CH_W'((int'(rr_q) + i) % NUM_CH);
      end
   end

   assign drain = (|hold_valid_q) && bus.ip_ready_in;

   // Drain the selected hold, then accept or drop each photodetector arrival.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      rr_d         = rr_q;
      drop_n       = '0;
      if (drain) begin
         hold_valid_d[sel] = 1'b0;
         rr_d = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
      end
      // hold_valid_d already reflects a same-cycle drain of this channel.
      for (int c = 0; c < NUM_CH; c++) begin
         if (bus.pd_valid_in[c]) begin
            if (bus.pd_data_in[c].dst == my_id &&
                32'(bus.pd_data_in[c].dst) < NUM_ROUTERS &&
                !hold_valid_d[c]) begin
               hold_valid_d[c] = 1'b1;
               hold_data_d[c]  = bus.pd_data_in[c];
            end else begin
               drop_n = drop_n + 4'd1;
            end
         end
      end
      drop_sum  = {1'b0, rx_drop_q} + 17'(drop_n);
      rx_drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   // ---------------- registers ----------------
   // All control state, synchronously reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         cycle_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         tx_count_q   <= '0;
         mod_valid_q  <= '0;
         mod_data_q   <= '{default: '0};
         tx_sent_q    <= '0;
         hold_valid_q <= '0;
         hold_data_q  <= '{default: '0};
         rr_q         <= '0;
         rx_drop_q    <= '0;
      end else begin
         cycle_q      <= cycle_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         tx_count_q   <= tx_count_d;
         mod_valid_q  <= mod_valid_d;
         mod_data_q   <= mod_data_d;
         tx_sent_q    <= tx_sent_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         rr_q         <= rr_d;
         rx_drop_q    <= rx_drop_d;
      end
   end

   // ---------------- outputs ----------------
   assign bus.ip_ready_out    = !tx_full;
   assign bus.request_to_send = !tx_empty;
   assign bus.mod_valid_out   = mod_valid_q;
   assign bus.mod_data_out    = mod_data_q;
   assign bus.ip_valid_out    = |hold_valid_q;
   assign bus.ip_data_out     = hold_data_q[sel];
   assign tx_sent_count       = tx_sent_q;
   assign rx_drop_count       = rx_drop_q;

endmodule

// File: tb/tb_wdm_router.sv
// Directed bench for wdm_router: a per-cycle vector table for TX and RX flow,
// then hand sequences for timestamping, reset mid-traffic and drop saturation.

module tb_wdm_router;
   import wdm_router_pkg::*;

   localparam int         NUM_CH = 2;
   localparam logic [8:0] MY_ID  = 9'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] router_id;
   logic [31:0] tx_sent_count;
   logic [15:0] rx_drop_count;

   int n_vec = 0;
   int n_err = 0;

   wdm_router_if #(.NUM_CH(NUM_CH)) bus ();

   wdm_router #(
      .WIDTH(32), .NUM_ROUTERS(4), .NUM_CH(NUM_CH), .TX_DEPTH(4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .router_id     (router_id),
      .tx_sent_count (tx_sent_count),
      .rx_drop_count (rx_drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      // inputs applied for one clock
      logic        ipv;
      logic [31:0] pay;
      logic [1:0]  grant;
      logic [1:0]  pdv;
      logic [8:0]  dst0, dst1;
      logic [31:0] pay0, pay1;
      logic        rdy;
      // expected outputs after that clock edge
      logic        e_ready, e_rts;
      logic [1:0]  e_modv;
      logic [31:0] e_m0, e_m1;
      logic        e_ipv;
      logic [31:0] e_ipd;
      logic [31:0] e_sent;
      logic [15:0] e_drop;
   } vec_t;

   vec_t vecs [24];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic packet_t pk(input logic [8:0] dst, input logic [31:0] pay);
      return '{valid: 1'b0, src: 9'd0, dst: dst, timestamp: 32'd0, payload: pay};
   endfunction

   task automatic idle();
      bus.ip_valid_in             = 1'b0;
      bus.ip_data_in              = pk(9'd0, 32'd0);
      bus.ip_ready_in             = 1'b0;
      bus.permission_granted_send = '0;
      bus.pd_valid_in             = '0;
      bus.pd_data_in[0]           = pk(9'd0, 32'd0);
      bus.pd_data_in[1]           = pk(9'd0, 32'd0);
   endtask

   initial begin
      //          ipv pay    gnt    pdv    d0 d1 pay0   pay1   rdy | rdy rts modv   m0     m1     ipv ipd    sent drop
      vecs[0]  = '{1, 32'h11, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 0,   1, 1, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0};
      vecs[1]  = '{1, 32'h12, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 0,   1, 1, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0};
      vecs[2]  = '{1, 32'h13, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 0,   1, 1, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0};
      vecs[3]  = '{1, 32'h14, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 0,   0, 1, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0};
      vecs[4]  = '{1, 32'h15, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 0,   0, 1, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0};
      vecs[5]  = '{1, 32'h15, 2'b01, 2'b00, 0, 0, 32'h0, 32'h0, 0,   1, 1, 2'b01, 32'h11, 32'h0, 0, 32'h0, 1, 0};
      vecs[6]  = '{1, 32'h15, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 0,   0, 1, 2'b00, 32'h11, 32'h0, 0, 32'h0, 1, 0};
      vecs[7]  = '{0, 32'h0,  2'b10, 2'b00, 0, 0, 32'h0, 32'h0, 0,   1, 1, 2'b10, 32'h11, 32'h12, 0, 32'h0, 2, 0};
      vecs[8]  = '{1, 32'h16, 2'b11, 2'b00, 0, 0, 32'h0, 32'h0, 0,   1, 1, 2'b01, 32'h13, 32'h12, 0, 32'h0, 3, 0};
      vecs[9]  = '{0, 32'h0,  2'b01, 2'b00, 0, 0, 32'h0, 32'h0, 0,   1, 1, 2'b01, 32'h14, 32'h12, 0, 32'h0, 4, 0};
      vecs[10] = '{0, 32'h0,  2'b01, 2'b00, 0, 0, 32'h0, 32'h0, 0,   1, 1, 2'b01, 32'h15, 32'h12, 0, 32'h0, 5, 0};
      vecs[11] = '{0, 32'h0,  2'b01, 2'b00, 0, 0, 32'h0, 32'h0, 0,   1, 0, 2'b01, 32'h16, 32'h12, 0, 32'h0, 6, 0};
      vecs[12] = '{0, 32'h0,  2'b01, 2'b00, 0, 0, 32'h0, 32'h0, 0,   1, 0, 2'b00, 32'h16, 32'h12, 0, 32'h0, 6, 0};
      vecs[13] = '{0, 32'h0,  2'b00, 2'b11, 3, 3, 32'hA0, 32'hA1, 1, 1, 0, 2'b00, 32'h16, 32'h12, 1, 32'hA0, 6, 0};
      vecs[14] = '{0, 32'h0,  2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 1,   1, 0, 2'b00, 32'h16, 32'h12, 1, 32'hA1, 6, 0};
      vecs[15] = '{0, 32'h0,  2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 1,   1, 0, 2'b00, 32'h16, 32'h12, 0, 32'h0, 6, 0};
      vecs[16] = '{0, 32'h0,  2'b00, 2'b10, 0, 3, 32'h0, 32'hB1, 0,  1, 0, 2'b00, 32'h16, 32'h12, 1, 32'hB1, 6, 0};
      vecs[17] = '{0, 32'h0,  2'b00, 2'b10, 0, 3, 32'h0, 32'hB2, 0,  1, 0, 2'b00, 32'h16, 32'h12, 1, 32'hB1, 6, 1};
      vecs[18] = '{0, 32'h0,  2'b00, 2'b01, 7, 0, 32'hC0, 32'h0, 0,  1, 0, 2'b00, 32'h16, 32'h12, 1, 32'hB1, 6, 2};
      vecs[19] = '{0, 32'h0,  2'b00, 2'b01, 3, 0, 32'hB3, 32'h0, 0,  1, 0, 2'b00, 32'h16, 32'h12, 1, 32'hB3, 6, 2};
      vecs[20] = '{0, 32'h0,  2'b00, 2'b01, 3, 0, 32'hB4, 32'h0, 1,  1, 0, 2'b00, 32'h16, 32'h12, 1, 32'hB1, 6, 2};
      vecs[21] = '{0, 32'h0,  2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 1,   1, 0, 2'b00, 32'h16, 32'h12, 1, 32'hB4, 6, 2};
      vecs[22] = '{0, 32'h0,  2'b00, 2'b11, 3, 9, 32'hB5, 32'hC1, 1, 1, 0, 2'b00, 32'h16, 32'h12, 1, 32'hB5, 6, 3};
      vecs[23] = '{0, 32'h0,  2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 1,   1, 0, 2'b00, 32'h16, 32'h12, 0, 32'h0, 6, 3};

      router_id = {7'd0, MY_ID};
      idle();

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      check("rst ip_ready_out", 32'(bus.ip_ready_out), 32'd1);
      check("rst request_to_send", 32'(bus.request_to_send), 32'd0);
      check("rst ip_valid_out", 32'(bus.ip_valid_out), 32'd0);
      check("rst mod_valid_out", 32'(bus.mod_valid_out), 32'd0);
      check("rst tx_sent_count", tx_sent_count, 32'd0);
      check("rst rx_drop_count", 32'(rx_drop_count), 32'd0);
      rst = 1'b0;

      // Table-driven cycles
      for (int i = 0; i < 24; i++) begin
         bus.ip_valid_in             = vecs[i].ipv;
         bus.ip_data_in              = pk(9'd5, vecs[i].pay);
         bus.permission_granted_send = vecs[i].grant;
         bus.pd_valid_in             = vecs[i].pdv;
         bus.pd_data_in[0]           = pk(vecs[i].dst0, vecs[i].pay0);
         bus.pd_data_in[1]           = pk(vecs[i].dst1, vecs[i].pay1);
         bus.ip_ready_in             = vecs[i].rdy;
         tick();
         check($sformatf("v%0d ip_ready_out", i), 32'(bus.ip_ready_out), 32'(vecs[i].e_ready));
         check($sformatf("v%0d request_to_send", i), 32'(bus.request_to_send), 32'(vecs[i].e_rts));
         check($sformatf("v%0d mod_valid_out", i), 32'(bus.mod_valid_out), 32'(vecs[i].e_modv));
         check($sformatf("v%0d mod_data0", i), bus.mod_data_out[0].payload, vecs[i].e_m0);
         check($sformatf("v%0d mod_data1", i), bus.mod_data_out[1].payload, vecs[i].e_m1);
         check($sformatf("v%0d ip_valid_out", i), 32'(bus.ip_valid_out), 32'(vecs[i].e_ipv));
         if (vecs[i].e_ipv)
            check($sformatf("v%0d ip_data_out", i), bus.ip_data_out.payload, vecs[i].e_ipd);
         check($sformatf("v%0d tx_sent_count", i), tx_sent_count, vecs[i].e_sent);
         check($sformatf("v%0d rx_drop_count", i), 32'(rx_drop_count), 32'(vecs[i].e_drop));
      end

      // Timestamp and source stamping: push at cycle counter 100
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (100) tick();
      bus.ip_data_in  = '{valid: 1'b0, src: 9'h1FF, dst: 9'd2, timestamp: 32'hDEAD, payload: 32'hABCD};
      bus.ip_valid_in = 1'b1;
      tick();
      bus.ip_valid_in             = 1'b0;
      bus.permission_granted_send = 2'b11;
      tick();
      bus.permission_granted_send = 2'b00;
      check("ts mod_valid_out", 32'(bus.mod_valid_out), 32'h1);
      check("ts timestamp", bus.mod_data_out[0].timestamp, 32'd100);
      check("ts src", 32'(bus.mod_data_out[0].src), 32'd3);
      check("ts valid", 32'(bus.mod_data_out[0].valid), 32'd1);
      check("ts dst", 32'(bus.mod_data_out[0].dst), 32'd2);
      check("ts payload", bus.mod_data_out[0].payload, 32'hABCD);
      tick();
      check("ts strobe one cycle", 32'(bus.mod_valid_out), 32'h0);
      check("ts data held", bus.mod_data_out[0].payload, 32'hABCD);

      // Reset with 3 TX entries and 2 occupied holds
      bus.ip_valid_in   = 1'b1;
      bus.ip_data_in    = pk(9'd1, 32'hE1);
      bus.pd_valid_in   = 2'b11;
      bus.pd_data_in[0] = pk(MY_ID, 32'hD0);
      bus.pd_data_in[1] = pk(MY_ID, 32'hD1);
      tick();
      bus.ip_data_in    = pk(9'd1, 32'hE2);
      bus.pd_valid_in   = 2'b01;
      bus.pd_data_in[0] = pk(MY_ID, 32'hD2);
      tick();
      bus.ip_data_in    = pk(9'd1, 32'hE3);
      bus.pd_valid_in   = 2'b00;
      tick();
      idle();
      check("pre-rst request_to_send", 32'(bus.request_to_send), 32'd1);
      check("pre-rst ip_valid_out", 32'(bus.ip_valid_out), 32'd1);
      check("pre-rst rx_drop_count", 32'(rx_drop_count), 32'd1);
      check("pre-rst tx_sent_count", tx_sent_count, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid-rst request_to_send", 32'(bus.request_to_send), 32'd0);
      check("mid-rst ip_valid_out", 32'(bus.ip_valid_out), 32'd0);
      check("mid-rst ip_ready_out", 32'(bus.ip_ready_out), 32'd1);
      check("mid-rst tx_sent_count", tx_sent_count, 32'd0);
      check("mid-rst rx_drop_count", 32'(rx_drop_count), 32'd0);
      check("mid-rst mod_valid_out", 32'(bus.mod_valid_out), 32'd0);
      check("mid-rst mod_data0", bus.mod_data_out[0].payload, 32'd0);

      // Drop counter saturation, two drops per cycle
      bus.pd_valid_in   = 2'b11;
      bus.pd_data_in[0] = pk(9'd9, 32'hF0);
      bus.pd_data_in[1] = pk(9'd9, 32'hF1);
      repeat (32767) tick();
      check("sat below limit", 32'(rx_drop_count), 32'hFFFE);
      tick();
      check("sat reaches limit", 32'(rx_drop_count), 32'hFFFF);
      tick();
      check("sat stays at limit", 32'(rx_drop_count), 32'hFFFF);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
